// File: rtl/omp_pkg.sv
// omp_pkg: shared widths and FSM encoding for the OMP core, support buffer and block C
package omp_pkg;
    localparam int IDX_W = 6;
    localparam int MAX_K = 16;
    localparam int CNT_W = 5;
    localparam int N_MAX = 64;
    localparam int PTR_W = $clog2(MAX_K);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} omp_state_t;
endpackage

// File: rtl/omp_lambda_list.sv
// omp_lambda_list: MAX_K x IDX_W register array, sync write, async read, sync clear
module omp_lambda_list
    import omp_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [IDX_W-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [IDX_W-1:0] rdata
);
    logic [IDX_W-1:0] mem [MAX_K];
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MAX_K; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/omp_support_buffer.sv
// omp_support_buffer: collects core lambdas into an ordered list and bitmap, then drains them in order
module omp_support_buffer
    import omp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_omp,
    input  logic             lambda_we,
    input  logic [IDX_W-1:0] lambda_in,
    input  logic             done_omp,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_pos,
    output logic             rd_last,
    output logic             list_done,
    output logic [N_MAX-1:0] support_map,
    output logic [CNT_W-1:0] support_cnt,
    output logic             dup_err,
    output logic             ovf_err,
    output logic             busy
);
    omp_state_t state, state_nxt;
    logic [CNT_W-1:0] rd_ptr, cnt_acc;
    logic [IDX_W-1:0] rd_data;
    logic collect, full, seen, accept, xfer, last, done_nxt;
    assign collect  = state == COLLECT;
    assign full     = support_cnt == CNT_W'(MAX_K);
    assign seen     = support_map[lambda_in];
    assign accept   = collect & lambda_we & !full & !seen;
    assign cnt_acc  = support_cnt + CNT_W'(accept);
    assign rd_valid = state == DRAIN;
    assign last     = rd_ptr == support_cnt - 1'b1;
    assign rd_last  = rd_valid & last;
    assign rd_idx   = rd_valid ? rd_data : '0;
    assign rd_pos   = rd_valid ? rd_ptr : '0;
    assign xfer     = rd_valid & rd_ready;
    assign busy     = collect | rd_valid;
    // the DRAIN/DONE choice looks at the count including a lambda accepted in the same cycle
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (start_omp) begin
            state_nxt = COLLECT;
        end else if (collect && done_omp) begin
            state_nxt = cnt_acc != '0 ? DRAIN : DONE;
            done_nxt  = cnt_acc == '0;
        end else if (xfer && last) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            list_done   <= 1'b0;
            support_map <= '0;
            support_cnt <= '0;
            dup_err     <= 1'b0;
            ovf_err     <= 1'b0;
            rd_ptr      <= '0;
        end else begin
            state     <= state_nxt;
            list_done <= done_nxt;
            if (start_omp) begin
                support_map <= '0;
                support_cnt <= '0;
                dup_err     <= 1'b0;
                ovf_err     <= 1'b0;
                rd_ptr      <= '0;
            end else begin
                if (accept) begin
                    support_map[lambda_in] <= 1'b1;
                    support_cnt            <= cnt_acc;
                end
                if (collect && lambda_we && full) ovf_err <= 1'b1;
                if (collect && lambda_we && !full && seen) dup_err <= 1'b1;
                if (xfer) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    omp_lambda_list u_list (
        .clk   (clk),
        .clr   (!rst_n || start_omp),
        .we    (accept),
        .waddr (support_cnt[PTR_W-1:0]),
        .wdata (lambda_in),
        .raddr (rd_ptr[PTR_W-1:0]),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_omp_support_buffer.sv
// tb_omp_support_buffer: directed scoreboard bench for omp_support_buffer
module tb_omp_support_buffer;
    import omp_pkg::*;
    logic clk = 0, rst_n = 0, start_omp = 0, lambda_we = 0, done_omp = 0, rd_ready = 0;
    logic [IDX_W-1:0] lambda_in = '0;
    logic rd_valid, rd_last, list_done, dup_err, ovf_err, busy;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_pos, support_cnt;
    logic [N_MAX-1:0] support_map;
    int checks = 0, errors = 0;
    logic [IDX_W-1:0] exp_q [$];
    logic [N_MAX-1:0] exp_map;
    int exp_cnt;
    logic exp_dup, exp_ovf;

    omp_support_buffer dut (
        .clk(clk), .rst_n(rst_n), .start_omp(start_omp), .lambda_we(lambda_we),
        .lambda_in(lambda_in), .done_omp(done_omp), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_idx(rd_idx), .rd_pos(rd_pos), .rd_last(rd_last), .list_done(list_done),
        .support_map(support_map), .support_cnt(support_cnt), .dup_err(dup_err),
        .ovf_err(ovf_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_map = '0;
        exp_cnt = 0;
        exp_dup = 0;
        exp_ovf = 0;
    endtask

    task automatic model_offer(input logic [IDX_W-1:0] l);
        if (exp_cnt == MAX_K) exp_ovf = 1;
        else if (exp_map[l]) exp_dup = 1;
        else begin
            exp_q.push_back(l);
            exp_map[l] = 1;
            exp_cnt++;
        end
    endtask

    task automatic start();
        start_omp = 1;
        model_clear();
        @(negedge clk);
        start_omp = 0;
    endtask

    task automatic offer(input logic [IDX_W-1:0] l, input logic with_done);
        lambda_we = 1;
        lambda_in = l;
        done_omp = with_done;
        model_offer(l);
        @(negedge clk);
        lambda_we = 0;
        done_omp = 0;
    endtask

    task automatic finish_collect();
        done_omp = 1;
        @(negedge clk);
        done_omp = 0;
    endtask

    task automatic chk_store(input string tag);
        chk({tag, "_map"}, support_map, exp_map);
        chk({tag, "_cnt"}, 64'(support_cnt), 64'(exp_cnt));
        chk({tag, "_dup"}, 64'(dup_err), 64'(exp_dup));
        chk({tag, "_ovf"}, 64'(ovf_err), 64'(exp_ovf));
    endtask

    // stall_mode gives rd_ready 1,0,0,...; stop_after>0 leaves the drain after that many transfers
    task automatic drain(input string tag, input bit stall_mode, input int stop_after);
        int pos = 0;
        bit done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            rd_ready = stall_mode ? (c % 3 == 0) : 1'b1;
            if (exp_q.size() > 0) begin
                chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
                chk({tag, "_idx"}, 64'(rd_idx), 64'(exp_q[0]));
                chk({tag, "_pos"}, 64'(rd_pos), 64'(pos));
                chk({tag, "_last"}, 64'(rd_last), 64'(exp_q.size() == 1));
                chk({tag, "_done_low"}, 64'(list_done), 64'd0);
                if (rd_ready) begin
                    void'(exp_q.pop_front());
                    pos++;
                    if (pos == stop_after) done = 1;
                end
            end else begin
                chk({tag, "_valid_end"}, 64'(rd_valid), 64'd0);
                chk({tag, "_list_done"}, 64'(list_done), 64'd1);
                chk({tag, "_busy_end"}, 64'(busy), 64'd0);
                done = 1;
            end
            @(negedge clk);
        end
        rd_ready = 0;
        if (stop_after == 0) begin
            chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
            chk({tag, "_done_pulse"}, 64'(list_done), 64'd0);
            chk({tag, "_valid_after"}, 64'(rd_valid), 64'd0);
        end
    endtask

    task automatic chk_cleared(input string tag, input logic exp_busy);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_idx"}, 64'(rd_idx), 64'd0);
        chk({tag, "_pos"}, 64'(rd_pos), 64'd0);
        chk({tag, "_last"}, 64'(rd_last), 64'd0);
        chk({tag, "_list_done"}, 64'(list_done), 64'd0);
        chk({tag, "_map"}, support_map, 64'd0);
        chk({tag, "_cnt"}, 64'(support_cnt), 64'd0);
        chk({tag, "_dup"}, 64'(dup_err), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk_cleared("reset", 1'b0);
        rst_n = 1;
        @(negedge clk);
        chk_cleared("idle", 1'b0);

        // T1: basic collect and full-speed drain
        start();
        chk("t1_busy", 64'(busy), 64'd1);
        offer(6'd5, 0);
        offer(6'd12, 0);
        offer(6'd40, 0);
        offer(6'd63, 0);
        chk_store("t1");
        chk("t1_map_const", support_map, 64'h8000_0100_0000_1020);
        finish_collect();
        drain("t1", 0, 0);
        chk_store("t1_hold");

        // T2: duplicate dropped; last lambda arrives with done_omp
        start();
        chk_cleared("t2_start", 1'b1);
        offer(6'd7, 0);
        offer(6'd7, 0);
        offer(6'd9, 1);
        chk_store("t2");
        chk("t2_dup_const", 64'(dup_err), 64'd1);
        chk("t2_cnt_const", 64'(support_cnt), 64'd2);
        drain("t2", 0, 0);

        // T3: overflow; 17th lambda (48) rejected
        start();
        for (int i = 0; i < 17; i++) offer(6'(i * 3), 0);
        chk_store("t3");
        chk("t3_ovf_const", 64'(ovf_err), 64'd1);
        chk("t3_cnt_const", 64'(support_cnt), 64'd16);
        chk("t3_map48", 64'(support_map[48]), 64'd0);
        finish_collect();
        drain("t3", 0, 0);

        // T4: drain with stalls
        start();
        offer(6'd33, 0);
        offer(6'd2, 0);
        offer(6'd50, 0);
        offer(6'd17, 0);
        offer(6'd0, 0);
        finish_collect();
        drain("t4", 1, 0);
        chk_store("t4");

        // T5: empty list
        start();
        finish_collect();
        chk("t5_valid", 64'(rd_valid), 64'd0);
        chk("t5_list_done", 64'(list_done), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t5_pulse", 64'(list_done), 64'd0);
        chk("t5_valid2", 64'(rd_valid), 64'd0);
        chk_store("t5");

        // T6: restart mid-drain, then reset mid-collect
        start();
        offer(6'd10, 0);
        offer(6'd20, 0);
        offer(6'd30, 0);
        offer(6'd40, 0);
        finish_collect();
        drain("t6a", 0, 2);
        start_omp = 1;
        rd_ready = 1;
        lambda_we = 1;
        lambda_in = 6'd44;
        done_omp = 1;
        model_clear();
        @(negedge clk);
        start_omp = 0;
        rd_ready = 0;
        lambda_we = 0;
        done_omp = 0;
        chk_cleared("t6_restart", 1'b1);
        offer(6'd8, 0);
        chk("t6_map8", 64'(support_map[8]), 64'd1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_clear();
        chk_cleared("t6_reset", 1'b0);
        start();
        offer(6'd1, 0);
        offer(6'd2, 0);
        finish_collect();
        drain("t6b", 0, 0);
        chk_store("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
